// File: rtl/mem_scan_engine.sv
// Sweeps every word of NUM_BANKS banks to fill, check or check+scrub, counting mismatches and recording the first.
// Per word: fill 2 cycles, check RD_LAT+2, scrubbed error RD_LAT+3; no backpressure, abort ends the run on the next edge.
module mem_scan_engine #(
  parameter int NUM_BANKS = 20,
  parameter int BANK_AW   = 8,
  parameter int DW        = 16,
  parameter int CNT_W     = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [1:0]               i_mode,
  input  logic [DW-1:0]            i_pattern,
  input  logic                     i_checker,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_aborted,
  output logic [CNT_W-1:0]         o_err_count,
  output logic                     o_first_err_valid,
  output logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] o_first_err_bank,
  output logic [BANK_AW-1:0]       o_first_err_addr,
  output logic [NUM_BANKS-1:0]     o_mem_cs,
  output logic [BANK_AW-1:0]       o_mem_addr,
  output logic [DW-1:0]            o_mem_wdata,
  output logic                     o_mem_we,
  input  logic [DW-1:0]            i_mem_rdata
);

  localparam int BW     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [BW-1:0]      LAST_BANK = BW'(NUM_BANKS - 1);
  localparam logic [BANK_AW-1:0] LAST_ADDR = '1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_WAIT, S_CMP, S_SCRUB, S_NEXT, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [1:0]         r_mode;
  logic [DW-1:0]      r_pattern;
  logic               r_checker;
  logic [BW-1:0]      r_bank;
  logic [BANK_AW-1:0] r_addr, r_addr_hold;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_err_count;
  logic               r_first_valid;
  logic [BW-1:0]      r_first_bank;
  logic [BANK_AW-1:0] r_first_addr;
  logic               r_aborted;

  logic               w_start, w_abort, w_fill, w_drive, w_mismatch, w_last_word;
  logic [DW-1:0]      w_exp;

  assign w_fill      = (r_mode == 2'd0);
  assign w_exp       = r_pattern ^ {DW{r_checker & r_addr[0]}};
  assign w_mismatch  = (i_mem_rdata != w_exp);
  assign w_last_word = (r_addr == LAST_ADDR) && (r_bank == LAST_BANK);
  assign w_start     = (r_state == S_IDLE) && i_start;
  assign w_abort     = i_abort && (r_state != S_IDLE) && (r_state != S_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_DONE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_next = (i_mode == 2'd0) ? S_WRITE : S_READ;
        S_WRITE: w_next = S_NEXT;
        S_READ:  w_next = (RD_LAT == 1) ? S_CMP : S_WAIT;
        S_WAIT:  if (r_wait == WAIT_LAST) w_next = S_CMP;
        S_CMP:   w_next = (w_mismatch && r_mode == 2'd2) ? S_SCRUB : S_NEXT;
        S_SCRUB: w_next = S_NEXT;
        S_NEXT:  w_next = w_last_word ? S_DONE : (w_fill ? S_WRITE : S_READ);
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy   = (r_state != S_IDLE) && (r_state != S_DONE);
    o_done   = (r_state == S_DONE);
    w_drive  = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_SCRUB);
    o_mem_we = (r_state == S_WRITE) || (r_state == S_SCRUB);
    o_mem_cs = w_drive ? (NUM_BANKS'(1) << r_bank) : '0;
  end

  // An abort discards any in-flight compare, so status only moves when no abort is pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode        <= '0;
      r_pattern     <= '0;
      r_checker     <= 1'b0;
      r_bank        <= '0;
      r_addr        <= '0;
      r_addr_hold   <= '0;
      r_wait        <= '0;
      r_err_count   <= '0;
      r_first_valid <= 1'b0;
      r_first_bank  <= '0;
      r_first_addr  <= '0;
      r_aborted     <= 1'b0;
    end else begin
      if (w_drive) r_addr_hold <= r_addr;
      if (w_start) begin
        r_mode        <= i_mode;
        r_pattern     <= i_pattern;
        r_checker     <= i_checker;
        r_bank        <= '0;
        r_addr        <= '0;
        r_err_count   <= '0;
        r_first_valid <= 1'b0;
        r_first_bank  <= '0;
        r_first_addr  <= '0;
        r_aborted     <= 1'b0;
      end else if (w_abort) begin
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          S_READ: r_wait <= '0;
          S_WAIT: r_wait <= r_wait + WAIT_W'(1);
          S_CMP: begin
            if (w_mismatch) begin
              if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
              if (!r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_bank  <= r_bank;
                r_first_addr  <= r_addr;
              end
            end
          end
          S_NEXT: begin
            r_addr <= r_addr + BANK_AW'(1);
            if (r_addr == LAST_ADDR && r_bank != LAST_BANK) r_bank <= r_bank + BW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign o_aborted         = r_aborted;
  assign o_err_count       = r_err_count;
  assign o_first_err_valid = r_first_valid;
  assign o_first_err_bank  = r_first_bank;
  assign o_first_err_addr  = r_first_addr;
  assign o_mem_addr        = w_drive ? r_addr : r_addr_hold;
  assign o_mem_wdata       = w_exp;

endmodule

// File: tb/tb_mem_scan_engine.sv
// Bench for mem_scan_engine: 2 banks x 4 words behind a 1-cycle bank model; bus ops scoreboarded in order.
// A second instance with a 2-bit error counter shares all inputs to exercise counter saturation.
module tb_mem_scan_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0, i_abort = 1'b0, i_checker = 1'b0;
  logic [1:0]  i_mode = 2'd0;
  logic [15:0] i_pattern = 16'h0;
  logic        o_busy, o_done, o_aborted, o_fev, o_we;
  logic [3:0]  o_err;
  logic        o_fbank;
  logic [1:0]  o_faddr, o_cs, o_addr;
  logic [15:0] o_wdata;
  logic [15:0] rdata = 16'h0;

  logic        s_busy, s_done, s_aborted, s_fev, s_we, s_fbank;
  logic [1:0]  s_err, s_faddr, s_cs, s_addr;
  logic [15:0] s_wdata;

  logic [15:0] mem [2][4];
  logic        inj_en = 1'b0;
  int          inj_b = 0, inj_a = 0;
  logic [15:0] inj_d = 16'h0;

  logic [31:0] exp_q[$];
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, last_rd = 0;
  logic        scrub_run = 1'b0;

  always #5 clk = ~clk;

  mem_scan_engine #(.NUM_BANKS(2), .BANK_AW(2), .DW(16), .CNT_W(4), .RD_LAT(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_mode(i_mode),
    .i_pattern(i_pattern), .i_checker(i_checker), .o_busy(o_busy), .o_done(o_done),
    .o_aborted(o_aborted), .o_err_count(o_err), .o_first_err_valid(o_fev),
    .o_first_err_bank(o_fbank), .o_first_err_addr(o_faddr), .o_mem_cs(o_cs),
    .o_mem_addr(o_addr), .o_mem_wdata(o_wdata), .o_mem_we(o_we), .i_mem_rdata(rdata));

  mem_scan_engine #(.NUM_BANKS(2), .BANK_AW(2), .DW(16), .CNT_W(2), .RD_LAT(1)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_mode(i_mode),
    .i_pattern(i_pattern), .i_checker(i_checker), .o_busy(s_busy), .o_done(s_done),
    .o_aborted(s_aborted), .o_err_count(s_err), .o_first_err_valid(s_fev),
    .o_first_err_bank(s_fbank), .o_first_err_addr(s_faddr), .o_mem_cs(s_cs),
    .o_mem_addr(s_addr), .o_mem_wdata(s_wdata), .o_mem_we(s_we), .i_mem_rdata(rdata));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Bank model: one-cycle registered read, write on cs & we; injection port for fault planting.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (inj_en) mem[inj_b][inj_a] <= inj_d;
    for (int b = 0; b < 2; b++) begin
      if (o_cs[b]) begin
        if (o_we) mem[b][o_addr] <= o_wdata;
        else      rdata <= mem[b][o_addr];
      end
    end
  end

  function automatic logic [31:0] op(input logic we, input int b, input int a, input logic [15:0] d);
    logic [1:0] cs;
    logic [1:0] ad;
    cs = 2'(1 << b);
    ad = 2'(a);
    return {11'd0, we, cs, ad, d};
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] pat, input logic chk, input int a);
    return (chk && (a % 2 == 1)) ? ~pat : pat;
  endfunction

  always @(negedge clk) begin
    if (rst_n && o_cs != 2'b00) begin
      logic [31:0] act;
      act = {11'd0, o_we, o_cs, o_addr, o_we ? o_wdata : 16'h0};
      if (exp_q.size() == 0) begin
        check("unexpected_op", act, 32'hFFFF_FFFF);
      end else begin
        check("bus_op", act, exp_q.pop_front());
      end
      if (!o_we) last_rd = cyc;
      else if (scrub_run) check("scrub_latency", 32'(cyc - last_rd), 32'd2);
    end
  end

  task automatic push_run(input logic [1:0] mode, input logic [15:0] pat, input logic chk);
    scrub_run = (mode == 2'd2);
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 4; a++) begin
        if (mode == 2'd0) exp_q.push_back(op(1'b1, b, a, exp_word(pat, chk, a)));
        else begin
          exp_q.push_back(op(1'b0, b, a, 16'h0));
          if (mode == 2'd2 && mem[b][a] != exp_word(pat, chk, a))
            exp_q.push_back(op(1'b1, b, a, exp_word(pat, chk, a)));
        end
      end
    end
  endtask

  task automatic run(input logic [1:0] mode, input logic [15:0] pat, input logic chk, output int cycles);
    push_run(mode, pat, chk);
    @(negedge clk);
    i_start = 1'b1; i_mode = mode; i_pattern = pat; i_checker = chk;
    @(negedge clk);
    i_start = 1'b0;
    cycles = 1;
    while (!o_done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (!o_done) check("done_timeout", 32'd0, 32'd1);
    check("busy_at_done", 32'(o_busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic inject(input int b, input int a, input logic [15:0] d);
    @(negedge clk);
    inj_en = 1'b1; inj_b = b; inj_a = a; inj_d = d;
    @(negedge clk);
    inj_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cs_we"}, {30'd0, o_cs} | 32'(o_we), 32'd0);
    check({tag, "_busy_done_ab"}, {29'd0, o_busy, o_done, o_aborted}, 32'd0);
    check({tag, "_err_first"}, {25'd0, o_err, o_fev, o_fbank, o_faddr}, 32'd0);
    check({tag, "_addr_wdata"}, {14'd0, o_addr, o_wdata}, 32'd0);
  endtask

  initial begin
    int cycles;
    int reads;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;

    // 1: checkerboard fill, 8 writes, done on cycle 2*2*4+1.
    run(2'd0, 16'hA5A5, 1'b1, cycles);
    check("fill_cycles", 32'(cycles), 32'd17);
    check("fill_err", 32'(o_err), 32'd0);
    check("fill_mem_b1a1", 32'(mem[1][1]), 32'h5A5A);

    // 2: clean check, reads only.
    run(2'd1, 16'hA5A5, 1'b1, cycles);
    check("check_cycles", 32'(cycles), 32'd25);
    check("check_err", {27'd0, o_fev, o_err}, 32'd0);

    // 3: single fault, check only.
    inject(1, 2, 16'h0000);
    run(2'd1, 16'hA5A5, 1'b1, cycles);
    check("fault_err", 32'(o_err), 32'd1);
    check("fault_first", {28'd0, o_fev, o_fbank, o_faddr}, {28'd0, 1'b1, 1'b1, 2'd2});
    check("fault_kept", 32'(mem[1][2]), 32'h0000);

    // 4: scrub repairs it; a re-check is clean.
    run(2'd2, 16'hA5A5, 1'b1, cycles);
    check("scrub_cycles", 32'(cycles), 32'd26);
    check("scrub_err", 32'(o_err), 32'd1);
    check("scrub_mem", 32'(mem[1][2]), 32'hA5A5);
    run(2'd1, 16'hA5A5, 1'b1, cycles);
    check("recheck_err", 32'(o_err), 32'd0);

    // 5: every word bad; 2-bit counter saturates.
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 4; a++) inject(b, a, 16'h0000);
    run(2'd1, 16'hA5A5, 1'b1, cycles);
    check("all_bad_err", 32'(o_err), 32'd8);
    check("sat_err", 32'(s_err), 32'd3);
    check("all_bad_first", {28'd0, o_fev, o_fbank, o_faddr}, {28'd0, 1'b1, 1'b0, 2'd0});

    // 6a: abort during the third read; a start mid-run must be ignored.
    scrub_run = 1'b0;
    for (int a = 0; a < 3; a++) exp_q.push_back(op(1'b0, 0, a, 16'h0));
    @(negedge clk);
    i_start = 1'b1; i_mode = 2'd1; i_pattern = 16'hA5A5; i_checker = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    reads = 0;
    for (int t = 0; t < 40 && reads < 3; t++) begin
      if (o_cs != 2'b00 && !o_we) begin
        reads++;
        if (reads == 2) i_start = 1'b1;
        if (reads == 3) i_abort = 1'b1;
      end
      if (reads < 3) begin
        @(negedge clk);
        i_start = 1'b0;
        i_mode = 2'd0;
      end
    end
    if (reads < 3) check("abort_reads_timeout", 32'(reads), 32'd3);
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_done", {30'd0, o_done, o_aborted}, 32'd3);
    check("abort_cs_busy", {29'd0, o_cs, o_busy}, 32'd0);
    check("abort_err", 32'(o_err), 32'd2);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("post_abort_idle", {28'd0, o_cs, o_busy, o_done}, 32'd0);
    end
    check("abort_status_hold", 32'(o_aborted), 32'd1);
    check("abort_queue", 32'(exp_q.size()), 32'd0);

    // 6b: asynchronous reset in the middle of a fill.
    push_run(2'd0, 16'h1234, 1'b0);
    @(negedge clk);
    i_start = 1'b1; i_mode = 2'd0; i_pattern = 16'h1234; i_checker = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", 32'(o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(2'd0, 16'h1234, 1'b0, cycles);
    check("post_reset_fill", 32'(cycles), 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
